// File: rtl/freelist.sv
// freelist: physical-register free list feeding a 4-wide rename stage.
// It is a circular FIFO of physical tags 1..SIZE-1. Tag 0 is never handed
// out and never taken back, because every architectural register maps to p0
// at reset.
// Each cycle it can allocate up to four tags (all-or-nothing, zero latency)
// and take back up to four freed tags from commit.
// Optional feature: define FREELIST_ERR_EN to add the sticky o_err flag. It
// flags overflow and double-free protocol violations.
module freelist #(
    parameter int WIDTH = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_req,
    output logic               o_gnt,
    output logic [4*WIDTH-1:0] o_ptag4x,
    input  logic [3:0]         i_free,
    input  logic [4*WIDTH-1:0] i_ftag4x,
    output logic [WIDTH-1:0]   o_count
`ifdef FREELIST_ERR_EN
    ,
    output logic               o_err
`endif
);

    localparam int SIZE = 2 ** WIDTH;
    localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};

    // Zero-extend a small slot count to pointer width.
    function automatic logic [WIDTH-1:0] ext3(input logic [2:0] v);
        return {{(WIDTH-3){1'b0}}, v};
    endfunction

    logic [WIDTH-1:0] ram_r [SIZE];
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [WIDTH-1:0] count_r;

    logic [2:0]       req_rank_s [4];
    logic [2:0]       n_req_s;
    logic [WIDTH-1:0] granted_s;
    logic [WIDTH-1:0] remain_s;
    logic [WIDTH-1:0] room_s;
    logic [3:0]       fvalid_s;
    logic [3:0]       facc_s;
    logic [2:0]       free_rank_s [4];
    logic [2:0]       n_acc_s;
    logic [WIDTH-1:0] count_next_s;
`ifdef FREELIST_ERR_EN
    logic [2:0]       n_fvalid_s;
`endif

    // Allocation: rank each requesting slot and read tags in order from head.
    always_comb begin : alloc_comb
        logic [2:0] run;
        run = 3'd0;
        o_ptag4x = {(4*WIDTH){1'b0}};
        for (int k = 0; k < 4; k++) begin
            req_rank_s[k] = run;
            run = run + {2'b00, i_req[k]};
        end
        n_req_s = run;
        o_gnt = (count_r >= ext3(n_req_s));
        granted_s = o_gnt ? ext3(n_req_s) : {WIDTH{1'b0}};
        for (int k = 0; k < 4; k++) begin
            o_ptag4x[k*WIDTH +: WIDTH] = ram_r[head_r + ext3(req_rank_s[k])];
        end
    end

    // Free: drop tag-0 frees and compact the rest. Frees that would
    // overfill the list are refused, so count saturates and pointers stay sane.
    always_comb begin : free_comb
        logic [2:0] run;
        logic [2:0] acc_run;
        run = 3'd0;
        acc_run = 3'd0;
        remain_s = count_r - granted_s;
        room_s = MAX_CNT - remain_s;
        for (int k = 0; k < 4; k++) begin
            fvalid_s[k] = i_free[k] && (i_ftag4x[k*WIDTH +: WIDTH] != {WIDTH{1'b0}});
            free_rank_s[k] = run;
            facc_s[k] = fvalid_s[k] && (ext3(run) < room_s);
            run = run + {2'b00, fvalid_s[k]};
            acc_run = acc_run + {2'b00, facc_s[k]};
        end
        n_acc_s = acc_run;
        count_next_s = remain_s + ext3(n_acc_s);
`ifdef FREELIST_ERR_EN
        n_fvalid_s = run;
`endif
    end

    // Storage, pointers and count. Reset reloads the list with tags 1..SIZE-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < SIZE; j++) begin
                ram_r[j] <= WIDTH'(j + 1);
            end
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= MAX_CNT;
            count_r <= MAX_CNT;
        end else begin
            head_r  <= head_r + granted_s;
            tail_r  <= tail_r + ext3(n_acc_s);
            count_r <= count_next_s;
            for (int k = 0; k < 4; k++) begin
                if (facc_s[k]) begin
                    ram_r[tail_r + ext3(free_rank_s[k])] <= i_ftag4x[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign o_count = count_r;

`ifdef FREELIST_ERR_EN
    logic ovf_s;
    logic dup_s;
    logic err_r;

    // Violation detect: overflow of the list, or a freed tag already held.
    always_comb begin : err_comb
        logic [WIDTH-1:0] off;
        logic             occ;
        ovf_s = (({1'b0, remain_s} + {1'b0, ext3(n_fvalid_s)}) > {1'b0, MAX_CNT});
        dup_s = 1'b0;
        off   = {WIDTH{1'b0}};
        occ   = 1'b0;
        for (int j = 0; j < SIZE; j++) begin
            off = WIDTH'(j) - head_r;
            occ = (off < count_r);
            for (int k = 0; k < 4; k++) begin
                dup_s = dup_s | (fvalid_s[k] & occ &
                                 (ram_r[j] == i_ftag4x[k*WIDTH +: WIDTH]));
            end
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_r <= 1'b0;
        end else if (ovf_s || dup_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign o_err = err_r;
`endif

endmodule

// File: tb/tb_freelist.sv
// tb_freelist: directed self-checking bench for freelist (WIDTH = 5).
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge.
module tb_freelist;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic        gnt;
    logic [19:0] ptag4x;
    logic [3:0]  free;
    logic [19:0] ftag4x;
    logic [4:0]  count;
`ifdef FREELIST_ERR_EN
    logic        err;
`endif

    int total_cnt;
    int pass_cnt;

    freelist #(.WIDTH(5)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .o_gnt    (gnt),
        .o_ptag4x (ptag4x),
        .i_free   (free),
        .i_ftag4x (ftag4x),
        .o_count  (count)
`ifdef FREELIST_ERR_EN
        ,
        .o_err    (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] slot(input int k);
        return ptag4x[k*5 +: 5];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        free = 4'b0000;
        ftag4x = 20'd0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (gnt !== 1'b1) $display("FAIL reset_gnt: got %0d expected 1", gnt);
        else pass_cnt++;
        total_cnt++;
        if (count !== 5'd31) $display("FAIL reset_count: got %0d expected 31", count);
        else pass_cnt++;
        total_cnt++;
        if (slot(0) !== 5'd1) $display("FAIL reset_slot0: got %0d expected 1", slot(0));
        else pass_cnt++;
    endtask

    task automatic test_alloc4();
        logic [4:0] exp_tag;
        do_reset();
        req = 4'b1111;
        @(negedge clk);
        total_cnt++;
        if (gnt !== 1'b1) $display("FAIL alloc4_gnt: got %0d expected 1", gnt);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            exp_tag = 5'(k + 1);
            total_cnt++;
            if (slot(k) !== exp_tag) $display("FAIL alloc4_slot%0d: got %0d expected %0d", k, slot(k), exp_tag);
            else pass_cnt++;
        end
        step();
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd27) $display("FAIL alloc4_count: got %0d expected 27", count);
        else pass_cnt++;
    endtask

    task automatic test_sparse();
        do_reset();
        req = 4'b1010;
        @(negedge clk);
        total_cnt++;
        if (slot(1) !== 5'd1) $display("FAIL sparse_slot1: got %0d expected 1", slot(1));
        else pass_cnt++;
        total_cnt++;
        if (slot(3) !== 5'd2) $display("FAIL sparse_slot3: got %0d expected 2", slot(3));
        else pass_cnt++;
        step();
        req = 4'b0001;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd29) $display("FAIL sparse_count: got %0d expected 29", count);
        else pass_cnt++;
        total_cnt++;
        if (slot(0) !== 5'd3) $display("FAIL sparse_next_slot0: got %0d expected 3", slot(0));
        else pass_cnt++;
        step();
        req = 4'b0000;
    endtask

    task automatic test_empty();
        logic [4:0] exp_tag;
        do_reset();
        req = 4'b1111;
        repeat (7) step();
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd3) $display("FAIL empty_count3: got %0d expected 3", count);
        else pass_cnt++;
        step();
        req = 4'b1111;
        @(negedge clk);
        total_cnt++;
        if (gnt !== 1'b0) $display("FAIL empty_deny_gnt: got %0d expected 0", gnt);
        else pass_cnt++;
        step();
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd3) $display("FAIL empty_deny_count: got %0d expected 3", count);
        else pass_cnt++;
        step();
        req = 4'b0111;
        @(negedge clk);
        total_cnt++;
        if (gnt !== 1'b1) $display("FAIL empty_last3_gnt: got %0d expected 1", gnt);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            exp_tag = 5'(29 + k);
            total_cnt++;
            if (slot(k) !== exp_tag) $display("FAIL empty_last3_slot%0d: got %0d expected %0d", k, slot(k), exp_tag);
            else pass_cnt++;
        end
        step();
        req = 4'b0001;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd0) $display("FAIL empty_count0: got %0d expected 0", count);
        else pass_cnt++;
        total_cnt++;
        if (gnt !== 1'b0) $display("FAIL empty_gnt0: got %0d expected 0", gnt);
        else pass_cnt++;
        step();
        req = 4'b0000;
    endtask

    // Continues from the empty state left by test_empty.
    task automatic test_free_tag0();
        free = 4'b0011;
        ftag4x = {5'd0, 5'd0, 5'd7, 5'd0};
        step();
        free = 4'b0000;
        ftag4x = 20'd0;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd1) $display("FAIL free0_count: got %0d expected 1", count);
        else pass_cnt++;
        step();
        req = 4'b0001;
        @(negedge clk);
        total_cnt++;
        if (gnt !== 1'b1) $display("FAIL free0_gnt: got %0d expected 1", gnt);
        else pass_cnt++;
        total_cnt++;
        if (slot(0) !== 5'd7) $display("FAIL free0_tag: got %0d expected 7", slot(0));
        else pass_cnt++;
        step();
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd0) $display("FAIL free0_after_count: got %0d expected 0", count);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [4:0] exp_tag;
        do_reset();
        req = 4'b1111;
        repeat (6) step();
        req = 4'b0111;
        step();
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd4) $display("FAIL wrap_count4: got %0d expected 4", count);
        else pass_cnt++;
        step();
        req = 4'b1111;
        free = 4'b1111;
        ftag4x = {5'd12, 5'd11, 5'd10, 5'd9};
        @(negedge clk);
        total_cnt++;
        if (gnt !== 1'b1) $display("FAIL wrap_gnt: got %0d expected 1", gnt);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            exp_tag = 5'(28 + k);
            total_cnt++;
            if (slot(k) !== exp_tag) $display("FAIL wrap_old_slot%0d: got %0d expected %0d", k, slot(k), exp_tag);
            else pass_cnt++;
        end
        step();
        req = 4'b0000;
        free = 4'b0000;
        ftag4x = 20'd0;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd4) $display("FAIL wrap_net_count: got %0d expected 4", count);
        else pass_cnt++;
        step();
        req = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_tag = 5'(9 + k);
            total_cnt++;
            if (slot(k) !== exp_tag) $display("FAIL wrap_new_slot%0d: got %0d expected %0d", k, slot(k), exp_tag);
            else pass_cnt++;
        end
        step();
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd0) $display("FAIL wrap_final_count: got %0d expected 0", count);
        else pass_cnt++;
    endtask

    task automatic test_full_saturate();
        logic [4:0] exp_tag;
        do_reset();
        free = 4'b0001;
        ftag4x = {15'd0, 5'd5};
        step();
        free = 4'b0000;
        ftag4x = 20'd0;
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd31) $display("FAIL full_count: got %0d expected 31", count);
        else pass_cnt++;
        step();
        req = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_tag = 5'(k + 1);
            total_cnt++;
            if (slot(k) !== exp_tag) $display("FAIL full_slot%0d: got %0d expected %0d", k, slot(k), exp_tag);
            else pass_cnt++;
        end
        step();
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111;
        free = 4'b0001;
        ftag4x = {15'd0, 5'd3};
        repeat (3) step();
        req = 4'b0001;
        free = 4'b0000;
        ftag4x = 20'd0;
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if (count !== 5'd31) $display("FAIL rstmid_count: got %0d expected 31", count);
        else pass_cnt++;
        total_cnt++;
        if (slot(0) !== 5'd1) $display("FAIL rstmid_slot0: got %0d expected 1", slot(0));
        else pass_cnt++;
        total_cnt++;
        if (gnt !== 1'b1) $display("FAIL rstmid_gnt: got %0d expected 1", gnt);
        else pass_cnt++;
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd31) $display("FAIL rstmid_release_count: got %0d expected 31", count);
        else pass_cnt++;
    endtask

`ifdef FREELIST_ERR_EN
    task automatic test_err();
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_reset: got %0d expected 0", err);
        else pass_cnt++;
        step();
        free = 4'b0001;
        ftag4x = {15'd0, 5'd5};
        step();
        free = 4'b0000;
        ftag4x = 20'd0;
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL err_overflow: got %0d expected 1", err);
        else pass_cnt++;
        step();
        step();
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %0d expected 1", err);
        else pass_cnt++;
        do_reset();
        req = 4'b1111;
        step();
        req = 4'b0000;
        free = 4'b0001;
        ftag4x = {15'd0, 5'd2};
        step();
        free = 4'b0000;
        ftag4x = 20'd0;
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_legal_free: got %0d expected 0", err);
        else pass_cnt++;
        step();
        free = 4'b0001;
        ftag4x = {15'd0, 5'd10};
        step();
        free = 4'b0000;
        ftag4x = 20'd0;
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL err_double_free: got %0d expected 1", err);
        else pass_cnt++;
    endtask
`endif

    initial begin
        total_cnt = 0;
        pass_cnt = 0;
        rst_n = 1'b0;
        req = 4'b0000;
        free = 4'b0000;
        ftag4x = 20'd0;
        test_reset();
        test_alloc4();
        test_sparse();
        test_empty();
        test_free_tag0();
        test_wrap();
        test_full_saturate();
        test_reset_mid();
`ifdef FREELIST_ERR_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
